// File: rtl/vram_tile_writer_pkg.sv
// rtl/vram_tile_writer_pkg.sv - shared widths, FSM encodings and constant shift-add multiply
package vram_tile_writer_pkg;

    localparam int COLOR_W    = 9;
    localparam int VRAM_AW    = 19;
    localparam int TILE_DEF   = 16;
    localparam int VRAM_W_DEF = 640;
    localparam int VRAM_H_DEF = 480;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [VRAM_AW-1:0] vaddr_t;

    // c is always an elaboration constant, so this folds into a fixed set of shifted adds
    function automatic vaddr_t mul_const(input vaddr_t x, input int unsigned c);
        vaddr_t acc;
        acc = '0;
        for (int k = 0; k < VRAM_AW; k++) begin
            if (c[k]) acc = acc + (x << k);
        end
        return acc;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// rtl/tile_addr_gen.sv - raster tx/ty counters, line_base accumulator, ROM and VRAM pixel address
module tile_addr_gen
    import vram_tile_writer_pkg::*;
#(
    parameter int TILE   = TILE_DEF,
    parameter int VRAM_W = VRAM_W_DEF,
    parameter int ID_W   = 6,
    localparam int TB    = $clog2(TILE)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ID_W-1:0]   id_i,
    input  vaddr_t            base_i,
    output logic [ID_W+2*TB-1:0] rom_adr_o,
    output vaddr_t            pix_adr_o,
    output logic              last_o
);

    logic [ID_W-1:0] id_q;
    logic [TB-1:0]   tx_q;
    logic [TB-1:0]   ty_q;
    vaddr_t          line_base_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            line_base_q <= '0;
        end else if (load_i) begin
            id_q        <= id_i;
            tx_q        <= '0;
            ty_q        <= '0;
            line_base_q <= base_i;
        end else if (adv_i) begin
            tx_q <= tx_q + 1'b1;
            if (tx_q == '1) begin
                ty_q        <= ty_q + 1'b1;
                line_base_q <= line_base_q + vaddr_t'(VRAM_W);
            end
        end
    end

    assign rom_adr_o = {id_q, ty_q, tx_q};
    assign pix_adr_o = line_base_q + vaddr_t'(tx_q);
    assign last_o    = (tx_q == '1) && (ty_q == '1);

endmodule

// File: rtl/vram_tile_writer.sv
// rtl/vram_tile_writer.sv - copies one TILE x TILE block (ROM or fill colour) into VRAM port B
module vram_tile_writer
    import vram_tile_writer_pkg::*;
#(
    parameter int TILE      = TILE_DEF,
    parameter int VRAM_W    = VRAM_W_DEF,
    parameter int VRAM_H    = VRAM_H_DEF,
    parameter int ID_W      = 6,
    parameter int SKIP_ZERO = 0,
    localparam int TB       = $clog2(TILE),
    localparam int RA_W     = ID_W + 2*TB
) (
    input  logic               clk_25mhz,
    input  logic               RST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_fill,
    input  logic [ID_W-1:0]    cmd_tile_id,
    input  logic [6:0]         cmd_col,
    input  logic [4:0]         cmd_row,
    input  logic [COLOR_W-1:0] fill_color,
    output logic [RA_W-1:0]    rom_adr,
    input  logic [COLOR_W-1:0] rom_dat,
    output logic [VRAM_AW-1:0] vram_adrb,
    output logic [COLOR_W-1:0] vram_datb,
    output logic               vram_web,
    output logic               done,
    output logic               err
);

    logic [1:0] state_q, state_d;
    logic       wr_q, err_q, fill_q;
    color_t     color_q;
    vaddr_t     adrb_q, adrb_d;

    vaddr_t col_px, row_px, base;
    logic   accept, in_bounds, run, last, skip;
    vaddr_t pix_adr;

    assign accept    = cmd_valid && cmd_ready;
    assign run       = (state_q == ST_RUN);
    assign col_px    = vaddr_t'(cmd_col) << TB;
    assign row_px    = vaddr_t'(cmd_row) << TB;
    assign in_bounds = ((col_px + vaddr_t'(TILE)) <= vaddr_t'(VRAM_W)) &&
                       ((row_px + vaddr_t'(TILE)) <= vaddr_t'(VRAM_H));
    assign base      = mul_const(row_px, VRAM_W) + col_px;

    tile_addr_gen #(
        .TILE   (TILE),
        .VRAM_W (VRAM_W),
        .ID_W   (ID_W)
    ) u_addr_gen (
        .clk_i     (clk_25mhz),
        .rst_i     (RST),
        .load_i    (accept && in_bounds),
        .adv_i     (run),
        .id_i      (cmd_tile_id),
        .base_i    (base),
        .rom_adr_o (rom_adr),
        .pix_adr_o (pix_adr),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = in_bounds ? ST_RUN : ST_DONE;
            ST_RUN:   if (last) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign adrb_d = run ? pix_adr : adrb_q;

    always_ff @(posedge clk_25mhz) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
            color_q <= '0;
            adrb_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= run;
            err_q   <= accept && !in_bounds;
            adrb_q  <= adrb_d;
            if (accept) begin
                fill_q  <= cmd_fill;
                color_q <= fill_color;
            end
        end
    end

    // rom_dat for a pixel arrives in its write cycle, so data and skip are resolved combinationally
    assign skip      = (SKIP_ZERO != 0) && !fill_q && (rom_dat == '0);
    assign vram_web  = wr_q && !skip;
    assign vram_datb = !wr_q ? '0 : (fill_q ? color_q : rom_dat);
    assign vram_adrb = adrb_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_vram_tile_writer.sv
// tb/tb_vram_tile_writer.sv - scoreboard bench for vram_tile_writer (plain and SKIP_ZERO instances)
module tb_vram_tile_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_fill = 1'b0;
    logic [5:0] cmd_tile_id = '0;
    logic [6:0] cmd_col = '0;
    logic [4:0] cmd_row = '0;
    logic [8:0] fill_color = '0;

    logic        rdy0, rdy1, web0, web1, done0, done1, err0, err1;
    logic [13:0] rom_adr0, rom_adr1;
    logic [8:0]  rom_dat0 = '0, rom_dat1 = '0;
    logic [18:0] adrb0, adrb1;
    logic [8:0]  datb0, datb1;

    typedef struct {
        int          c;
        logic [18:0] adr;
        logic [8:0]  dat;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_web = 0;
    bit  sel = 1'b0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_tile_writer #(.SKIP_ZERO(0)) dut0 (
        .clk_25mhz(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_fill(cmd_fill), .cmd_tile_id(cmd_tile_id), .cmd_col(cmd_col), .cmd_row(cmd_row),
        .fill_color(fill_color), .rom_adr(rom_adr0), .rom_dat(rom_dat0),
        .vram_adrb(adrb0), .vram_datb(datb0), .vram_web(web0), .done(done0), .err(err0)
    );

    vram_tile_writer #(.SKIP_ZERO(1)) dut1 (
        .clk_25mhz(clk), .RST(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_fill(cmd_fill), .cmd_tile_id(cmd_tile_id), .cmd_col(cmd_col), .cmd_row(cmd_row),
        .fill_color(fill_color), .rom_adr(rom_adr1), .rom_dat(rom_dat1),
        .vram_adrb(adrb1), .vram_datb(datb1), .vram_web(web1), .done(done1), .err(err1)
    );

    // Tile 5 is transparent at even tx; every other tile holds {id[0], ty, tx}
    function automatic logic [8:0] rom_fn(input logic [5:0] id, input logic [3:0] ty, input logic [3:0] tx);
        if (id == 6'd5) return tx[0] ? {1'b0, ty, tx} : 9'd0;
        return {id[0], ty, tx};
    endfunction

    always @(posedge clk) begin
        rom_dat0 <= rom_fn(rom_adr0[13:8], rom_adr0[7:4], rom_adr0[3:0]);
        rom_dat1 <= rom_fn(rom_adr1[13:8], rom_adr1[7:4], rom_adr1[3:0]);
    end

    always @(negedge clk) begin
        logic        w;
        logic [18:0] a;
        logic [8:0]  d;
        wr_t         e;
        w = sel ? web1 : web0;
        a = sel ? adrb1 : adrb0;
        d = sel ? datb1 : datb0;
        if (w === 1'b1) begin
            n_web++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write cyc=%0d adr=%0d dat=%h required=no write", cyc, a, d);
            end else begin
                e = exp_q.pop_front();
                if (a !== e.adr || d !== e.dat || cyc !== e.c) begin
                    n_bad++;
                    $display("FAIL write cyc=%0d adr=%0d dat=%h required cyc=%0d adr=%0d dat=%h",
                             cyc, a, d, e.c, e.adr, e.dat);
                end
            end
        end
    end

    task automatic push_expect(input int a, input logic f, input logic [5:0] id, input int col,
                               input int row, input logic [8:0] color, input bit skip, input int cutoff);
        wr_t e;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] tx, ty;
            tx    = 4'(i % 16);
            ty    = 4'(i / 16);
            e.dat = f ? color : rom_fn(id, ty, tx);
            e.c   = a + 2 + i;
            e.adr = 19'(row * 16 * 640 + col * 16 + (i / 16) * 640 + (i % 16));
            if (!(skip && !f && e.dat == 9'd0) && e.c <= cutoff) exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic f, input logic [5:0] id, input logic [6:0] col, input logic [4:0] row,
                         input logic [8:0] color, input bit hold, output int a);
        int k;
        cmd_fill = f; cmd_tile_id = id; cmd_col = col; cmd_row = row; fill_color = color;
        cmd_valid = 1'b1;
        k = 0;
        while (!(sel ? rdy1 : rdy0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout ready=0 required=1");
        end
        a = cyc;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc, output logic de);
        dc = -1; de = 1'bx;
        for (int k = 0; k < 700; k++) begin
            if ((sel ? done1 : done0) === 1'b1) begin
                dc = cyc; de = sel ? err1 : err0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_normal(input string nm, input int a, input int w0, input int nexp);
        int dc; logic de;
        wait_done(dc, de);
        n_cmp++; if (dc !== a + 258) begin n_bad++; $display("FAIL %s_done_cyc got=%0d required=%0d", nm, dc, a + 258); end
        n_cmp++; if (de !== 1'b0) begin n_bad++; $display("FAIL %s_err got=%b required=0", nm, de); end
        n_cmp++; if ((sel ? rdy1 : rdy0) !== 1'b0) begin n_bad++; $display("FAIL %s_ready_at_done got=1 required=0", nm); end
        @(negedge clk);
        n_cmp++; if ((sel ? rdy1 : rdy0) !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after got=0 required=1", nm); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL %s_missing_writes got=%0d left required=0", nm, exp_q.size()); end
        n_cmp++; if (n_web - w0 != nexp) begin n_bad++; $display("FAIL %s_web_count got=%0d required=%0d", nm, n_web - w0, nexp); end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b required=1", rdy0); end
        n_cmp++; if (web0 !== 1'b0) begin n_bad++; $display("FAIL reset_web got=%b required=0", web0); end
        n_cmp++; if (done0 !== 1'b0 || err0 !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got=%b%b required=00", done0, err0); end
        n_cmp++; if (adrb0 !== 19'd0 || datb0 !== 9'd0 || rom_adr0 !== 14'd0) begin
            n_bad++; $display("FAIL reset_outputs adrb=%0d datb=%0d rom_adr=%0d required=0", adrb0, datb0, rom_adr0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rom_copy();
        int a, w0;
        sel = 0; w0 = n_web;
        issue(1'b0, 6'd3, 7'd2, 5'd1, 9'd0, 1'b0, a);
        push_expect(a, 1'b0, 6'd3, 2, 1, 9'd0, 1'b0, 1 << 30);
        n_cmp++; if (exp_q[0].adr !== 19'd10272 || exp_q[0].dat !== 9'd256) begin
            n_bad++; $display("FAIL rom_first_model adr=%0d dat=%0d required adr=10272 dat=256", exp_q[0].adr, exp_q[0].dat);
        end
        check_normal("rom_copy", a, w0, 256);
    endtask

    task automatic test_fill();
        int a, w0;
        sel = 0; w0 = n_web;
        issue(1'b1, 6'd7, 7'd39, 5'd29, 9'h1C0, 1'b0, a);
        push_expect(a, 1'b1, 6'd7, 39, 29, 9'h1C0, 1'b0, 1 << 30);
        check_normal("fill", a, w0, 256);
    endtask

    task automatic test_reject();
        int a, w0, dc; logic de;
        sel = 0; w0 = n_web;
        issue(1'b1, 6'd0, 7'd40, 5'd0, 9'h1FF, 1'b0, a);
        wait_done(dc, de);
        n_cmp++; if (dc !== a + 1) begin n_bad++; $display("FAIL reject_done_cyc got=%0d required=%0d", dc, a + 1); end
        n_cmp++; if (de !== 1'b1) begin n_bad++; $display("FAIL reject_err got=%b required=1", de); end
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b1 || cyc !== a + 2) begin n_bad++; $display("FAIL reject_ready got=%b at %0d required=1 at %0d", rdy0, cyc, a + 2); end
        repeat (5) @(negedge clk);
        n_cmp++; if (n_web != w0) begin n_bad++; $display("FAIL reject_web_count got=%0d required=0", n_web - w0); end
    endtask

    task automatic test_skip_zero();
        int a, w0;
        sel = 1; w0 = n_web;
        issue(1'b0, 6'd5, 7'd4, 5'd2, 9'd0, 1'b0, a);
        push_expect(a, 1'b0, 6'd5, 4, 2, 9'd0, 1'b1, 1 << 30);
        check_normal("skip_zero", a, w0, 128);
        sel = 0;
    endtask

    task automatic test_reset_abort();
        int a, w0;
        sel = 0; w0 = n_web;
        issue(1'b0, 6'd3, 7'd0, 5'd0, 9'd0, 1'b0, a);
        push_expect(a, 1'b0, 6'd3, 0, 0, 9'd0, 1'b0, a + 100);
        while (cyc < a + 100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (web0 !== 1'b0) begin n_bad++; $display("FAIL abort_web got=%b required=0", web0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b required=1", rdy0); end
        rst = 1'b0;
        repeat (300) @(negedge clk);
        n_cmp++; if (n_web - w0 != 99 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL abort_web_count got=%0d left=%0d required=99 left=0", n_web - w0, exp_q.size());
        end
        w0 = n_web;
        issue(1'b1, 6'd0, 7'd0, 5'd0, 9'h055, 1'b0, a);
        push_expect(a, 1'b1, 6'd0, 0, 0, 9'h055, 1'b0, 1 << 30);
        check_normal("after_abort", a, w0, 256);
    endtask

    task automatic test_back_to_back();
        int a, a2, w0;
        sel = 0; w0 = n_web;
        issue(1'b0, 6'd2, 7'd5, 5'd3, 9'd0, 1'b1, a);
        push_expect(a, 1'b0, 6'd2, 5, 3, 9'd0, 1'b0, 1 << 30);
        a2 = a + 259;
        cmd_fill = 1'b1; cmd_col = 7'd10; cmd_row = 5'd7; fill_color = 9'h123;
        push_expect(a2, 1'b1, 6'd2, 10, 7, 9'h123, 1'b0, 1 << 30);
        while (cyc < a + 60) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            cmd_valid = k[0];
            fill_color = 9'h1FF;
            @(negedge clk);
        end
        fill_color = 9'h123;
        cmd_valid = 1'b1;
        while (cyc < a + 258) @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_early got=%b required=0", rdy0); end
        @(negedge clk);
        n_cmp++; if (rdy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_a259 got=%b required=1", rdy0); end
        @(negedge clk);
        cmd_valid = 1'b0;
        check_normal("back_to_back", a2, w0, 512);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rom_copy();
        test_fill();
        test_reject();
        test_skip_zero();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
